// File: rtl/blk_topk_sel.sv
// Top-K block selector: keeps the K best-scoring block indices in a sorted
// slot array while scores stream in, then drains them into the index RAM.
module blk_topk_sel #(
   parameter int K_MAX   = 16,
   parameter int SCORE_W = 32,
   parameter int IDX_W   = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic [IDX_W-1:0]   k_sel,
   input  logic [IDX_W-1:0]   n_blocks,
   input  logic [IDX_W-1:0]   wr_base,
   input  logic               score_valid,
   output logic               score_ready,
   input  logic [SCORE_W-1:0] score_data,
   output logic               idx_wen,
   output logic [IDX_W-1:0]   idx_waddr,
   output logic [IDX_W-1:0]   idx_wdata,
   output logic [IDX_W-1:0]   sel_count,
   output logic               busy,
   output logic               done
);

   localparam int PW = $clog2(K_MAX + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                     state_r;
   logic [PW-1:0]              k_eff_r;
   logic [PW-1:0]              len_r;
   logic [PW-1:0]              drain_cnt_r;
   logic [IDX_W-1:0]           n_blk_r;
   logic [IDX_W-1:0]           base_r;
   logic [IDX_W-1:0]           blk_cnt_r;

   logic signed [SCORE_W-1:0]  slot_score_r [K_MAX];
   logic [IDX_W-1:0]           slot_idx_r   [K_MAX];
   logic [K_MAX-1:0]           slot_vld_r;

   logic signed [SCORE_W-1:0]  new_score_s;
   logic [K_MAX-1:0]           ge_s;
   logic [K_MAX-1:0]           prev_ge_s;
   logic signed [SCORE_W-1:0]  up_score_s [K_MAX];
   logic [IDX_W-1:0]           up_idx_s   [K_MAX];
   logic [K_MAX-1:0]           up_vld_s;

   logic signed [SCORE_W-1:0]  ins_score_s [K_MAX];
   logic [IDX_W-1:0]           ins_idx_s   [K_MAX];
   logic [K_MAX-1:0]           ins_vld_s;

   logic [PW-1:0]              k_eff_s;
   logic [PW-1:0]              len_s;
   logic [PW-1:0]              drain_nxt_s;
   logic [IDX_W-1:0]           rd_idx_s;
   logic                       accept_s;
   logic                       last_s;

   // Operation parameters derived from the start-time inputs and handshake.
   always_comb begin
      k_eff_s     = (k_sel > IDX_W'(K_MAX)) ? PW'(K_MAX) : PW'(k_sel);
      len_s       = (n_blocks < IDX_W'(k_eff_s)) ? PW'(n_blocks) : k_eff_s;
      accept_s    = (state_r == COLLECT) && score_valid && score_ready;
      last_s      = accept_s && ((blk_cnt_r + IDX_W'(1)) == n_blk_r);
      new_score_s = $signed(score_data);
      drain_nxt_s = drain_cnt_r + PW'(1);
   end

   // Per-slot rank compare and the one-position-down view of the array.
   // Valid slots form a sorted prefix, so ge_s is itself a prefix mask and
   // its length is the insertion position; >= keeps earlier indices ahead on ties.
   always_comb begin
      prev_ge_s     = '0;
      prev_ge_s[0]  = 1'b1;
      up_vld_s      = '0;
      up_score_s[0] = '0;
      up_idx_s[0]   = '0;
      for (int i = 0; i < K_MAX; i++) begin
         ge_s[i] = slot_vld_r[i] && (slot_score_r[i] >= new_score_s);
      end
      for (int i = 1; i < K_MAX; i++) begin
         prev_ge_s[i]  = ge_s[i-1];
         up_score_s[i] = slot_score_r[i-1];
         up_idx_s[i]   = slot_idx_r[i-1];
         up_vld_s[i]   = slot_vld_r[i-1];
      end
   end

   // Array contents after inserting the incoming score (keep / insert / shift).
   always_comb begin
      ins_vld_s = slot_vld_r;
      for (int i = 0; i < K_MAX; i++) begin
         ins_score_s[i] = slot_score_r[i];
         ins_idx_s[i]   = slot_idx_r[i];
         if (PW'(i) >= k_eff_r) begin
            ins_vld_s[i] = slot_vld_r[i];
         end else if (ge_s[i]) begin
            ins_vld_s[i] = slot_vld_r[i];
         end else if (prev_ge_s[i]) begin
            ins_score_s[i] = new_score_s;
            ins_idx_s[i]   = blk_cnt_r;
            ins_vld_s[i]   = 1'b1;
         end else begin
            ins_score_s[i] = up_score_s[i];
            ins_idx_s[i]   = up_idx_s[i];
            ins_vld_s[i]   = up_vld_s[i];
         end
      end
   end

   // Read mux for the next slot to be drained.
   always_comb begin
      rd_idx_s = '0;
      for (int i = 0; i < K_MAX; i++) begin
         rd_idx_s = (drain_nxt_s == PW'(i)) ? slot_idx_r[i] : rd_idx_s;
      end
   end

   // Control FSM, slot array and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= IDLE;
         k_eff_r     <= '0;
         len_r       <= '0;
         drain_cnt_r <= '0;
         n_blk_r     <= '0;
         base_r      <= '0;
         blk_cnt_r   <= '0;
         slot_vld_r  <= '0;
         for (int i = 0; i < K_MAX; i++) begin
            slot_score_r[i] <= '0;
            slot_idx_r[i]   <= '0;
         end
         score_ready <= 1'b0;
         idx_wen     <= 1'b0;
         idx_waddr   <= '0;
         idx_wdata   <= '0;
         sel_count   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  k_eff_r    <= k_eff_s;
                  len_r      <= len_s;
                  n_blk_r    <= n_blocks;
                  base_r     <= wr_base;
                  blk_cnt_r  <= '0;
                  slot_vld_r <= '0;
                  sel_count  <= '0;
                  if ((k_eff_s == PW'(0)) || (n_blocks == IDX_W'(0))) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                  end else begin
                     state_r     <= COLLECT;
                     busy        <= 1'b1;
                     score_ready <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (accept_s) begin
                  slot_score_r <= ins_score_s;
                  slot_idx_r   <= ins_idx_s;
                  slot_vld_r   <= ins_vld_s;
                  blk_cnt_r    <= blk_cnt_r + IDX_W'(1);
               end
               // First write is launched from the post-insert view so the
               // final score can still claim slot 0.
               if (last_s) begin
                  state_r     <= DRAIN;
                  score_ready <= 1'b0;
                  idx_wen     <= 1'b1;
                  idx_waddr   <= base_r;
                  idx_wdata   <= ins_idx_s[0];
                  drain_cnt_r <= '0;
               end
            end
            DRAIN: begin
               if (drain_nxt_s < len_r) begin
                  idx_waddr   <= base_r + IDX_W'(drain_nxt_s);
                  idx_wdata   <= rd_idx_s;
                  drain_cnt_r <= drain_nxt_s;
               end else begin
                  idx_wen   <= 1'b0;
                  state_r   <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  sel_count <= IDX_W'(len_r);
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r     <= IDLE;
               score_ready <= 1'b0;
               idx_wen     <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blk_topk_sel.sv
// Table-driven bench for blk_topk_sel; expected index-RAM writes go into a
// scoreboard queue at start and are popped as the DUT writes.
module tb_blk_topk_sel;

   localparam int NV = 8;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] k_sel = '0;
   logic [15:0] n_blocks = '0;
   logic [15:0] wr_base = '0;
   logic        score_valid = 1'b0;
   logic        score_ready;
   logic [31:0] score_data = '0;
   logic        idx_wen;
   logic [15:0] idx_waddr;
   logic [15:0] idx_wdata;
   logic [15:0] sel_count;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int k;
      int n;
      int base;
      int gap;
      int cnt;
      bit inj;
   } vec_t;

   vec_t vecs [NV];
   int   vsc  [NV][20];
   int   vexp [NV][16];
   logic [31:0] exp_q [$];

   blk_topk_sel #(.K_MAX(16), .SCORE_W(32), .IDX_W(16)) dut (
      .clk(clk), .rstn(rstn), .start(start), .k_sel(k_sel), .n_blocks(n_blocks),
      .wr_base(wr_base), .score_valid(score_valid), .score_ready(score_ready),
      .score_data(score_data), .idx_wen(idx_wen), .idx_waddr(idx_waddr),
      .idx_wdata(idx_wdata), .sel_count(sel_count), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (idx_wen === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h expected none", idx_waddr, idx_wdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if ({idx_waddr, idx_wdata} !== e) begin
               errors++;
               $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                        idx_waddr, idx_wdata, e[31:16], e[15:0]);
            end
         end
      end
   end

   task automatic do_start(input int k, input int n, input int base);
      @(posedge clk); #1;
      k_sel = 16'(k); n_blocks = 16'(n); wr_base = 16'(base); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int v, input int cnt);
      for (int j = 0; j < cnt; j++) begin
         int budget;
         for (int g = 0; g < vecs[v].gap; g++) begin
            @(posedge clk); #1;
         end
         score_valid = 1'b1;
         score_data  = vsc[v][j];
         budget = 0;
         while (score_ready !== 1'b1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
         end
         if (budget >= 20) chk("ready_timeout", 32'(score_ready), 32'd1);
         @(posedge clk); #1;
         score_valid = 1'b0;
      end
   endtask

   task automatic run_vec(input int v);
      for (int i = 0; i < vecs[v].cnt; i++)
         exp_q.push_back({16'(vecs[v].base + i), 16'(vexp[v][i])});
      do_start(vecs[v].k, vecs[v].n, vecs[v].base);
      if (vecs[v].cnt == 0) begin
         chk($sformatf("v%0d_done_now", v), 32'(done), 32'd1);
         chk($sformatf("v%0d_ready_zero", v), 32'(score_ready), 32'd0);
         chk($sformatf("v%0d_selcnt_zero", v), 32'(sel_count), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_drop", v), 32'(done), 32'd0);
         chk($sformatf("v%0d_ready_stay0", v), 32'(score_ready), 32'd0);
      end else begin
         chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
         feed(v, vecs[v].n);
         chk($sformatf("v%0d_ready_drop", v), 32'(score_ready), 32'd0);
         for (int i = 0; i < vecs[v].cnt; i++) begin
            chk($sformatf("v%0d_wen_%0d", v, i), 32'(idx_wen), 32'd1);
            if (vecs[v].inj && i == 0) begin
               k_sel = 16'd1; n_blocks = 16'd1; wr_base = 16'h0AAA; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
         end
         chk($sformatf("v%0d_wen_off", v), 32'(idx_wen), 32'd0);
         chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
         chk($sformatf("v%0d_sel_count", v), 32'(sel_count), 32'(vecs[v].cnt));
         chk($sformatf("v%0d_busy_off", v), 32'(busy), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", v), 32'(done), 32'd0);
         chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
         chk($sformatf("v%0d_idle_ready", v), 32'(score_ready), 32'd0);
      end
      chk($sformatf("v%0d_sb_empty", v), 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           k   n   base     gap cnt inj
      vecs[0] = '{3,  8,  'h10,    0,  3,  1'b0};
      vecs[1] = '{0,  8,  'h20,    0,  0,  1'b0};
      vecs[2] = '{4,  0,  'h30,    0,  0,  1'b0};
      vecs[3] = '{20, 20, 'h100,   1,  16, 1'b0};
      vecs[4] = '{4,  2,  'h40,    0,  2,  1'b0};
      vecs[5] = '{4,  2,  'hFFFF,  0,  2,  1'b0};
      vecs[6] = '{4,  6,  'h50,    0,  4,  1'b1};
      vecs[7] = '{2,  3,  'h60,    0,  2,  1'b0};
      vsc[0]  = '{5, -2, 9, 9, 0, 7, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vexp[0] = '{2, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vsc[1]  = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vexp[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vsc[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vexp[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vsc[3]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
      vexp[3] = '{19, 18, 17, 16, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4};
      vsc[4]  = '{-8, -3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vexp[4] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vsc[5]  = vsc[4];
      vexp[5] = vexp[4];
      vsc[6]  = '{3, 3, 3, -1, 3, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vexp[6] = '{5, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vsc[7]  = '{32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vexp[7] = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(score_ready), 32'd0);
      chk("rst_wen", 32'(idx_wen), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_waddr", 32'(idx_waddr), 32'd0);
      chk("rst_wdata", 32'(idx_wdata), 32'd0);
      chk("rst_selcnt", 32'(sel_count), 32'd0);
      rstn = 1'b1;

      for (int v = 0; v < NV; v++) run_vec(v);

      // Abort mid-collection: three scores in, then asynchronous reset.
      do_start(vecs[0].k, vecs[0].n, vecs[0].base);
      feed(0, 3);
      #2 rstn = 1'b0;
      #1;
      chk("abort_ready", 32'(score_ready), 32'd0);
      chk("abort_wen", 32'(idx_wen), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_waddr", 32'(idx_waddr), 32'd0);
      chk("abort_wdata", 32'(idx_wdata), 32'd0);
      chk("abort_selcnt", 32'(sel_count), 32'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("post_abort_wen", 32'(idx_wen), 32'd0);
         chk("post_abort_busy", 32'(busy), 32'd0);
      end
      run_vec(0);

      repeat (3) @(posedge clk);
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
